// File: rtl/v68k_bus_pkg.sv
// Shared encodings for the V68k external bus controller: FSM states, function codes,
// strobe/direction levels and the operand-port error codes.
package v68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_WDS,
    ST_WAIT,
    ST_END,
    ST_ERR,
    ST_GRANT
  } bus_state_e;

  localparam logic [2:0] FC_USER_DATA = 3'b001;
  localparam logic [2:0] FC_USER_PROG = 3'b010;
  localparam logic [2:0] FC_SUPV_DATA = 3'b101;
  localparam logic [2:0] FC_SUPV_PROG = 3'b110;

  localparam logic DS_ON     = 1'b0;
  localparam logic DS_OFF    = 1'b1;
  localparam logic AS_STROBE = 1'b0;
  localparam logic AS_OFF    = 1'b1;
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

  localparam logic [1:0] DERR_OK   = 2'b00;
  localparam logic [1:0] DERR_BUS  = 2'b01;
  localparam logic [1:0] DERR_ADDR = 2'b10;

  function automatic logic [2:0] fc_code(input logic supervisor, input logic is_fetch);
    if (supervisor) return is_fetch ? FC_SUPV_PROG : FC_SUPV_DATA;
    return is_fetch ? FC_USER_PROG : FC_USER_DATA;
  endfunction

endpackage

// File: rtl/v68k_bus_timeout.sv
// Down-counter guarding the WAIT state: loaded when the strobes go out,
// expired_o flags that the allowed number of wait cycles has been used up.
module v68k_bus_timeout #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/v68k_bus_ctrl.sv
// Arbitrates the fetch and operand ports onto a 68000-style asynchronous bus,
// sequences AS/UDS/LDS/RW, and yields the bus to external masters between cycles.
module v68k_bus_ctrl
  import v68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 24
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              supervisor,
  input  logic              f_req,
  input  logic [ADDR_W-2:0] f_addr,
  output logic              f_ack,
  output logic [15:0]       f_rdata,
  output logic              f_berr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic              d_word,
  input  logic [15:0]       d_wdata,
  output logic              d_ack,
  output logic [15:0]       d_rdata,
  output logic [1:0]        d_err,
  output logic [ADDR_W-2:0] A,
  output logic              AS,
  output logic              UDS,
  output logic              LDS,
  output logic              RW,
  output logic [15:0]       D_out,
  output logic              D_oe,
  input  logic [15:0]       D_in,
  input  logic              DTACK,
  input  logic              BERR,
  input  logic              BR,
  output logic              BG,
  input  logic              BGACK,
  output logic [2:0]        FC
);

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  bus_state_e        state_q, state_d;
  logic              is_data_q, we_q, word_q, uds_en_q, lds_en_q, err_q, bgack_seen_q;
  logic [ADDR_W-2:0] a_q;
  logic [2:0]        fc_q;
  logic [15:0]       wdata_q, rdata_q, rd_val;
  logic              accept_d, accept_f, rd_latch, bus_err, to_expired;
  logic              in_cycle, strobing, ds_active;

  // Requesters hold req until their one-cycle ack; the loser of arbitration simply keeps waiting.
  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    accept_f = 1'b0;
    rd_latch = 1'b0;
    bus_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (BR) begin
          state_d = ST_GRANT;
        end else if (d_req) begin
          if (d_word && d_addr[0]) begin
            state_d = ST_ERR;
          end else begin
            state_d  = ST_ADDR;
            accept_d = 1'b1;
          end
        end else if (f_req) begin
          state_d  = ST_ADDR;
          accept_f = 1'b1;
        end
      end
      ST_ADDR:  state_d = ST_STRB;
      ST_STRB:  state_d = we_q ? ST_WDS : ST_WAIT;
      ST_WDS:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (BERR) begin
          state_d = ST_END;
          bus_err = 1'b1;
        end else if (DTACK) begin
          state_d  = ST_END;
          rd_latch = !we_q;
        end else if (to_expired) begin
          state_d = ST_END;
          bus_err = 1'b1;
        end
      end
      ST_END:   state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      ST_GRANT: if (!BR && !BGACK) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = D_in;
    if (!word_q) rd_val = uds_en_q ? {8'h00, D_in[15:8]} : {8'h00, D_in[7:0]};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      is_data_q    <= 1'b0;
      we_q         <= 1'b0;
      word_q       <= 1'b0;
      uds_en_q     <= 1'b0;
      lds_en_q     <= 1'b0;
      err_q        <= 1'b0;
      bgack_seen_q <= 1'b0;
      a_q          <= '0;
      fc_q         <= 3'b000;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept_d) begin
        is_data_q <= 1'b1;
        we_q      <= d_we;
        word_q    <= d_word;
        uds_en_q  <= d_word || !d_addr[0];
        lds_en_q  <= d_word || d_addr[0];
        a_q       <= d_addr[ADDR_W-1:1];
        fc_q      <= fc_code(supervisor, 1'b0);
        wdata_q   <= d_word ? d_wdata : {d_wdata[7:0], d_wdata[7:0]};
        err_q     <= 1'b0;
      end else if (accept_f) begin
        is_data_q <= 1'b0;
        we_q      <= 1'b0;
        word_q    <= 1'b1;
        uds_en_q  <= 1'b1;
        lds_en_q  <= 1'b1;
        a_q       <= f_addr;
        fc_q      <= fc_code(supervisor, 1'b1);
        err_q     <= 1'b0;
      end
      if (rd_latch) rdata_q <= rd_val;
      if (bus_err) err_q <= 1'b1;
      if (state_q != ST_GRANT) bgack_seen_q <= 1'b0;
      else if (BGACK) bgack_seen_q <= 1'b1;
    end
  end

  v68k_bus_timeout #(.W(16)) u_timeout (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .clr_i     (state_q == ST_IDLE),
    .load_i    ((state_q == ST_STRB) || (state_q == ST_WDS)),
    .load_val_i(TO_LOAD),
    .en_i      (state_q == ST_WAIT),
    .expired_o (to_expired)
  );

  // Writes hold the data strobes back one cycle (WDS) so D is stable before DS falls.
  assign in_cycle  = (state_q == ST_ADDR) || (state_q == ST_STRB) ||
                     (state_q == ST_WDS) || (state_q == ST_WAIT);
  assign strobing  = (state_q == ST_STRB) || (state_q == ST_WDS) || (state_q == ST_WAIT);
  assign ds_active = we_q ? ((state_q == ST_WDS) || (state_q == ST_WAIT))
                          : ((state_q == ST_STRB) || (state_q == ST_WAIT));

  assign A      = a_q;
  assign FC     = fc_q;
  assign AS     = strobing ? AS_STROBE : AS_OFF;
  assign UDS    = (ds_active && uds_en_q) ? DS_ON : DS_OFF;
  assign LDS    = (ds_active && lds_en_q) ? DS_ON : DS_OFF;
  assign RW     = (in_cycle && we_q) ? RW_WRITE : RW_READ;
  assign D_oe   = in_cycle && we_q;
  assign D_out  = wdata_q;
  assign BG     = (state_q == ST_GRANT) && !bgack_seen_q;

  assign f_ack   = (state_q == ST_END) && !is_data_q;
  assign f_berr  = f_ack && err_q;
  assign f_rdata = rdata_q;
  assign d_ack   = ((state_q == ST_END) && is_data_q) || (state_q == ST_ERR);
  assign d_rdata = rdata_q;
  assign d_err   = (state_q == ST_ERR) ? DERR_ADDR :
                   ((d_ack && err_q) ? DERR_BUS : DERR_OK);

endmodule
